// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared defaults, NZP condition-code encodings and helpers
//                for the scoreboarded register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry of the register file
    localparam int DATA_W_DEFAULT = 16;
    localparam int ADDR_W_DEFAULT = 3;
    localparam int CNT_W_DEFAULT  = 2;

    // Condition-code encodings, {N,Z,P}
    localparam logic [2:0] CC_N   = 3'b100;
    localparam logic [2:0] CC_Z   = 3'b010;
    localparam logic [2:0] CC_P   = 3'b001;

    // Condition code held after reset
    localparam logic [2:0] CC_RST = CC_Z;

    // One-hot NZP from the sign bit and a zero flag of a written value.
    // Zero takes priority so that a zero value never reports negative.
    function automatic logic [2:0] cc_encode(input logic sign, input logic zero);
        logic [2:0] cc;
        if (zero) begin
            cc = CC_Z;
        end else if (sign) begin
            cc = CC_N;
        end else begin
            cc = CC_P;
        end
        return cc;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb_pend_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pend_cnt
//  Description : Saturating up/down counter of outstanding writes for one
//                register. Reports busy (non-zero), full (at maximum) and
//                last (exactly one outstanding write).
//  Revision    : 1.0 - initial release
// ============================================================================
module pend_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic full,
    output logic last
);

    localparam logic [CNT_W-1:0] C_MAX = '1;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             inc_ok;
    logic             dec_ok;

    assign busy = (cnt_q != '0);
    assign full = (cnt_q == C_MAX);
    assign last = (cnt_q == C_ONE);

    // Never wrap: an increment at the ceiling or a decrement at zero is dropped
    assign inc_ok = inc && !full;
    assign dec_ok = dec && busy;

    // Next count; a simultaneous reservation and release cancel out
    always_comb begin
        cnt_d = cnt_q;
        case ({inc_ok, dec_ok})
            2'b10:   cnt_d = cnt_q + C_ONE;
            2'b01:   cnt_d = cnt_q - C_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Counter register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : pend_cnt
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Three-read / one-write register file with write-through
//                bypass, per-register pending-write scoreboard, stall
//                (busy) indication, reservation handshake, NZP condition
//                code generation and unreserved-write error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    // Decode-stage operand reads
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [ADDR_W-1:0] rd_addr_c,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] rd_data_c,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic              rd_busy_c,
    // Writeback port
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    // Destination reservation
    input  logic              alloc_valid,
    input  logic [ADDR_W-1:0] alloc_addr,
    output logic              alloc_ready,
    // Status
    output logic [2:0]        cc_nzp,
    output logic              wr_err
);

    localparam int DEPTH = 1 << ADDR_W;

    // Register storage and status state
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [2:0]        cc_q;
    logic [2:0]        cc_d;
    logic              err_q;
    logic              err_d;

    // Per-register scoreboard signals
    logic [DEPTH-1:0]  inc_w;
    logic [DEPTH-1:0]  dec_w;
    logic [DEPTH-1:0]  busy_w;
    logic [DEPTH-1:0]  full_w;
    logic [DEPTH-1:0]  last_w;

    // Bypass selects; a write in a reset cycle is discarded so it is not forwarded
    logic              byp_a;
    logic              byp_b;
    logic              byp_c;

    // ------------------------------------------------------------------
    // Scoreboard: one pending-write counter per register
    // ------------------------------------------------------------------
    // Reservation lookahead only looks at the current count; a release in
    // the same cycle does not free a slot early.
    assign alloc_ready = !full_w[alloc_addr];

    generate
        for (genvar r = 0; r < DEPTH; r++) begin : g_pend
            assign inc_w[r] = alloc_valid && alloc_ready && (alloc_addr == ADDR_W'(r));
            assign dec_w[r] = we && (wr_addr == ADDR_W'(r)) && busy_w[r];

            pend_cnt #(
                .CNT_W (CNT_W)
            ) u_pend_cnt (
                .clk  (clk),
                .rst  (rst),
                .inc  (inc_w[r]),
                .dec  (dec_w[r]),
                .busy (busy_w[r]),
                .full (full_w[r]),
                .last (last_w[r])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports with write-through bypass
    // ------------------------------------------------------------------
    assign byp_a = we && !rst && (wr_addr == rd_addr_a);
    assign byp_b = we && !rst && (wr_addr == rd_addr_b);
    assign byp_c = we && !rst && (wr_addr == rd_addr_c);

    assign rd_data_a = byp_a ? wr_data : data_q[rd_addr_a];
    assign rd_data_b = byp_b ? wr_data : data_q[rd_addr_b];
    assign rd_data_c = byp_c ? wr_data : data_q[rd_addr_c];

    // Busy drops early when the final outstanding write retires this cycle,
    // since its value is already on the bypass path.
    assign rd_busy_a = busy_w[rd_addr_a] &&
                       !(we && (wr_addr == rd_addr_a) && last_w[rd_addr_a]);
    assign rd_busy_b = busy_w[rd_addr_b] &&
                       !(we && (wr_addr == rd_addr_b) && last_w[rd_addr_b]);
    assign rd_busy_c = busy_w[rd_addr_c] &&
                       !(we && (wr_addr == rd_addr_c) && last_w[rd_addr_c]);

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign cc_nzp = cc_q;
    assign wr_err = err_q;

    // Next condition code and error flag from the writeback this cycle
    always_comb begin
        cc_d  = cc_q;
        err_d = 1'b0;
        if (we) begin
            cc_d  = cc_encode(wr_data[DATA_W-1], (wr_data == '0));
            err_d = !busy_w[wr_addr];
        end
    end

    // Data array: reset clears every register, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (we) begin
            data_q[wr_addr] <= wr_data;
        end
    end

    // Condition code and write-error pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q  <= CC_RST;
            err_q <= 1'b0;
        end else begin
            cc_q  <= cc_d;
            err_q <= err_d;
        end
    end

endmodule : regfile_sb
`default_nettype wire
